// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter and its round-robin picker.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StStall
  } arb_state_e;

  // Index width; at least one bit, so a two-entry pointer still toggles.
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                           input int unsigned n);
    int unsigned s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

  function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester handshake plus FIFO write-port bundle; master is the arbiter side.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
) ();
  localparam int unsigned PTR_W = fifo_arb_pkg::ptr_w(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      wr_full;
  logic                      wrreq;
  logic [DATA_W-1:0]         data_in;
  logic [PTR_W-1:0]          grant_id;

  modport master (
    input  req_valid, req_data, wr_full,
    output req_ready, wrreq, data_in, grant_id
  );

  modport slave (
    output req_valid, req_data, wr_full,
    input  req_ready, wrreq, data_in, grant_id
  );
endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: rotate by ptr, find first set, rotate the index back.
module rr_priority_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = ptr_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   idx,
  output logic               any
);
  logic [2*NUM_REQ-1:0] doubled;
  logic [NUM_REQ-1:0]   rotated;
  logic [PTR_W-1:0]     offset;

  assign doubled = {req_valid, req_valid};
  assign rotated = NUM_REQ'(doubled >> ptr);

  // Descending scan so the lowest set bit (nearest to ptr) wins.
  always_comb begin
    offset = '0;
    any    = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        offset = PTR_W'(k);
        any    = 1'b1;
      end
    end
  end

  assign idx = PTR_W'(wrap_add(32'(ptr), 32'(offset), NUM_REQ));

  always_comb begin
    grant = '0;
    if (any) grant[idx] = 1'b1;
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter feeding one FIFO write port from NUM_REQ producers.
// Optional FIFO_ARB_BURST_EN lets a winner hold the grant for up to MAX_BURST words.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input logic           wr_clk,
  input logic           rst_n,
  fifo_wr_arbiter_if.master bus
);
  localparam int unsigned PTR_W = ptr_w(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1) begin : g_bad_cfg
    $error("fifo_wr_arbiter: unsupported NUM_REQ or MAX_BURST");
  end

  arb_state_e           state_q;
  logic [DATA_W-1:0]    data_q;
  logic [PTR_W-1:0]     gid_q;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     win_idx;
  logic [NUM_REQ-1:0]   win_grant;
  logic                 win_any;
  logic                 out_valid;
  logic                 wrreq;
  logic                 load;

  assign out_valid = (state_q != StIdle);
  assign wrreq     = out_valid & ~bus.wr_full;
  // Gated by rst_n so no word is taken while reset is asserted.
  assign load      = rst_n & (~out_valid | wrreq);

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req_valid (bus.req_valid),
    .ptr       (ptr_q),
    .grant     (win_grant),
    .idx       (win_idx),
    .any       (win_any)
  );

  assign bus.req_ready = load ? win_grant : '0;
  assign bus.wrreq     = wrreq;
  assign bus.data_in   = data_q;
  assign bus.grant_id  = gid_q;

`ifdef FIFO_ARB_BURST_EN
  localparam int unsigned CNT_W = ptr_w(MAX_BURST);

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;

  // ptr_q parks on the burst owner; a different winner means the burst ended early.
  always_comb begin
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    cnt_base = (win_idx == ptr_q) ? cnt_q : '0;
    if (load && win_any) begin
      if (32'(cnt_base) == MAX_BURST - 1) begin
        ptr_d = PTR_W'(wrap_add(32'(win_idx), 1, NUM_REQ));
        cnt_d = '0;
      end else begin
        ptr_d = win_idx;
        cnt_d = cnt_base + 1'b1;
      end
    end else if (load && cnt_q != '0) begin
      ptr_d = PTR_W'(wrap_add(32'(ptr_q), 1, NUM_REQ));
      cnt_d = '0;
    end
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  always_comb begin
    ptr_d = ptr_q;
    if (load && win_any) ptr_d = PTR_W'(wrap_add(32'(win_idx), 1, NUM_REQ));
  end
`endif

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      data_q  <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (load) begin
        if (win_any) begin
          state_q <= StSend;
          data_q  <= bus.req_data[slice_lsb(32'(win_idx), DATA_W) +: DATA_W];
          gid_q   <= win_idx;
        end else begin
          state_q <= StIdle;
        end
      end else begin
        state_q <= StStall;
      end
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: driver pushes expected writes, monitor checks them.
module tb_fifo_wr_arbiter;
  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned MAX_BURST = 4;

  typedef struct packed {
    logic [1:0] gid;
    logic [7:0] data;
  } word_t;

  logic wr_clk = 1'b0;
  logic rst_n  = 1'b0;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .wr_clk (wr_clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 wr_clk = ~wr_clk;

  logic [7:0]         src_q [NUM_REQ][$];
  logic [NUM_REQ-1:0] en;
  word_t              exp_q [$];
  int                 n_checks = 0;
  int                 n_fail   = 0;
  logic               prev_acc = 1'b0;

  task automatic check_eq(input string name, input int unsigned act, input int unsigned req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_word(input int gid, input int data);
    word_t w;
    w.gid  = 2'(gid);
    w.data = 8'(data);
    exp_q.push_back(w);
  endtask

  function automatic logic src_busy();
    for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_valid[i] = en[i] && (src_q[i].size() != 0);
      bus.req_data[i*DATA_W +: DATA_W] = (src_q[i].size() != 0) ? src_q[i][0] : 8'h00;
    end
  endtask

  // One clock: sample acceptance away from the edge, retire taken words after it.
  task automatic step();
    logic [NUM_REQ-1:0] acc;
    drive();
    @(negedge wr_clk);
    acc = bus.req_ready & bus.req_valid;
    @(posedge wr_clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) if (acc[i]) void'(src_q[i].pop_front());
    drive();
  endtask

  task automatic drain(input string name, input int max_cycles);
    int c;
    c = 0;
    while ((src_busy() || exp_q.size() != 0) && c < max_cycles) begin
      step();
      c++;
    end
    check_eq({name, "_drained"}, 32'(exp_q.size()) + 32'(src_busy()), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    exp_q.delete();
    en          = '1;
    bus.wr_full = 1'b0;
    drive();
    @(posedge wr_clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge wr_clk) begin : monitor
    word_t w;
    if (rst_n) begin
      check_eq("ready_without_valid", 32'(bus.req_ready & ~bus.req_valid), 0);
      check_eq("ready_onehot", 32'($countones(bus.req_ready) <= 1), 1);
      if (prev_acc && !bus.wr_full) check_eq("latency", 32'(bus.wrreq), 1);
      if (bus.wrreq) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got gid %0d data 0x%0h, expected no write",
                   bus.grant_id, bus.data_in);
        end else begin
          w = exp_q.pop_front();
          check_eq("wr_data", 32'(bus.data_in), 32'(w.data));
          check_eq("wr_gid", 32'(bus.grant_id), 32'(w.gid));
        end
      end
      prev_acc = |(bus.req_ready & bus.req_valid);
    end else begin
      prev_acc = 1'b0;
    end
  end

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.wr_full   = 1'b0;
    en            = '1;
    rst_n         = 1'b0;
    @(posedge wr_clk);
    #1;
    check_eq("rst_wrreq", 32'(bus.wrreq), 0);
    check_eq("rst_data_in", 32'(bus.data_in), 0);
    check_eq("rst_grant_id", 32'(bus.grant_id), 0);
    check_eq("rst_req_ready", 32'(bus.req_ready), 0);
    @(posedge wr_clk);
    #1;
    rst_n = 1'b1;

    // Reset asserted mid-stall discards the held word.
    src_q[0].push_back(8'h11);
    src_q[0].push_back(8'h22);
    step();
    bus.wr_full = 1'b1;
    step();
    step();
    check_eq("t1_held", 32'(bus.data_in), 32'h11);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("t1_rst_wrreq", 32'(bus.wrreq), 0);
    check_eq("t1_rst_ready", 32'(bus.req_ready), 0);
    check_eq("t1_rst_data_in", 32'(bus.data_in), 0);
    src_q[0].delete();
    drive();
    @(posedge wr_clk);
    #1;
    bus.wr_full = 1'b0;
    rst_n       = 1'b1;
    drive();

    // All four valid straight out of reset: pointer starts at requester 0.
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < NUM_REQ; i++) src_q[i].push_back(8'(i * 16 + k));
`ifdef FIFO_ARB_BURST_EN
    for (int i = 0; i < NUM_REQ; i++)
      for (int k = 0; k < 4; k++) expect_word(i, i * 16 + k);
`else
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < NUM_REQ; i++) expect_word(i, i * 16 + k);
`endif
    drain("t3_all_valid", 200);

    // Single requester streams ten words back to back.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      src_q[0].push_back(8'(k));
      expect_word(0, k);
    end
    drain("t2_single", 200);

    // Full for five clocks holding 0xA5; req2 waits and drops valid mid-stall.
    do_reset();
    src_q[1].push_back(8'hA5);
    src_q[2].push_back(8'h5A);
    expect_word(1, 8'hA5);
    expect_word(2, 8'h5A);
    step();
    bus.wr_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) en[2] = 1'b0;
      if (c == 3) en[2] = 1'b1;
      drive();
      @(negedge wr_clk);
      check_eq("t4_stall_data", 32'(bus.data_in), 32'hA5);
      check_eq("t4_stall_ready", 32'(bus.req_ready), 0);
      check_eq("t4_stall_wrreq", 32'(bus.wrreq), 0);
      @(posedge wr_clk);
      #1;
    end
    bus.wr_full = 1'b0;
    drain("t4_stall", 200);

    // Move the pointer to 3, then only requesters 1 and 3 compete across the wrap.
    do_reset();
    src_q[2].push_back(8'h77);
    expect_word(2, 8'h77);
    drain("t5_setup", 50);
    src_q[1].push_back(8'h10);
    src_q[1].push_back(8'h11);
    src_q[3].push_back(8'h30);
    src_q[3].push_back(8'h31);
`ifdef FIFO_ARB_BURST_EN
    expect_word(3, 8'h30);
    expect_word(3, 8'h31);
    expect_word(1, 8'h10);
    expect_word(1, 8'h11);
`else
    expect_word(3, 8'h30);
    expect_word(1, 8'h10);
    expect_word(3, 8'h31);
    expect_word(1, 8'h11);
`endif
    drain("t5_wrap", 200);

    // Requesters 0 and 2 both loaded with six words.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      src_q[0].push_back(8'(8'h60 + k));
      src_q[2].push_back(8'(8'h80 + k));
    end
`ifdef FIFO_ARB_BURST_EN
    for (int k = 0; k < 4; k++) expect_word(0, 8'h60 + k);
    for (int k = 0; k < 4; k++) expect_word(2, 8'h80 + k);
    for (int k = 4; k < 6; k++) expect_word(0, 8'h60 + k);
    for (int k = 4; k < 6; k++) expect_word(2, 8'h80 + k);
`else
    for (int k = 0; k < 6; k++) begin
      expect_word(0, 8'h60 + k);
      expect_word(2, 8'h80 + k);
    end
`endif
    drain("t6_pair", 200);

    repeat (3) @(posedge wr_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
